exp_bias_add_pipe: RTL and testbench
====================================

EXP_BIAS_ADD_PIPE -- requirements
Module: exp_bias_add_pipe

Interface
REQ-001 Parameter EW, 5, exponent field width; legal range 4..11.
REQ-002 Parameter BIAS, 2**(EW-1)-1, exponent bias.
REQ-003 Parameter STAGES, 1, pipeline depth; legal values 1 or 2.
REQ-004 Parameter FTZ, 1, flush-to-zero enable: a zero exponent forces E_r to 0.
REQ-005 Parameter TAGW, 4, width of the sideband tag carried alongside each operation.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 in_valid  in  1  operand pair present.
REQ-009 in_ready  out  1  block accepts the operand pair this cycle.
REQ-010 E_a, E_b  in  EW each  biased exponent fields.
REQ-011 in_tag  in  TAGW  sideband tag, passed through unmodified.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 E_r  out  EW  clamped biased result exponent.
REQ-015 E_raw  out  EW+2  signed, unclamped E_a+E_b-BIAS, for the normalizer.
REQ-016 ovf, unf, zero, special  out  1 each  result flags.
REQ-017 out_tag  out  TAGW  tag of the result.

Function
REQ-018 Arithmetic: E_raw = E_a + E_b - BIAS, computed in EW+2-bit two's complement; it never wraps across the full input range.
REQ-019 special = (E_a == all-ones) or (E_b == all-ones).
REQ-020 zero = (E_a == 0) or (E_b == 0).
REQ-021 ovf = (E_raw >= 2**EW - 1) and not special.
REQ-022 unf = (E_raw <= 0) and not special and not zero.
REQ-023 E_r precedence: special -> all-ones; else zero with FTZ=1 -> 0; else ovf -> all-ones; else unf -> 0; else E_raw[EW-1:0].
REQ-024 special and zero may both be asserted (Inf*0); E_r is then all-ones.
REQ-025 With FTZ=0, zero inputs still assert the zero flag, and E_r follows the ovf/unf/E_raw rules.
REQ-026 Latency from accepted input to out_valid is exactly STAGES cycles when there is no backpressure.
REQ-027 Handshake: a transfer occurs when valid and ready are both high on a clock edge; there is no combinational path from in_valid to out_valid.
REQ-028 Each stage register loads when it is empty or its contents are being consumed in the same cycle; otherwise it holds.
REQ-029 in_ready = stage-1 empty, or stage-1 advancing this cycle; in_ready may depend combinationally on out_ready.
REQ-030 Throughput is one result per cycle with out_ready held high; no bubbles are inserted.
REQ-031 While out_valid=1 and out_ready=0, every output stays bit-stable.
REQ-032 Flags and E_r are computed in stage 1; with STAGES=2, stage 2 is a pure register slice.
REQ-033 On a simultaneous accept and drain of a full pipe, no result is lost or duplicated.

Reset
REQ-034 rst_n low clears every stage valid bit immediately; out_valid and in_ready go to 0 while rst_n is low.
REQ-035 Data and flag outputs reset to 0.
REQ-036 Reset mid-operation discards all in-flight results; the first accepted pair after release produces the next output.
REQ-037 in_ready returns to 1 on the first clock edge after rst_n is released.

Structure
REQ-038 A shared package fp_mac_pkg holds the format constants (EW/BIAS for FP16 = 5/15, BF16 = 8/127, FP32 = 8/127) and a packed flag struct {ovf, unf, zero, special}.
REQ-039 One sub-module, pipe_stage_reg, implements a single valid/ready register slice and is instantiated STAGES times.
REQ-040 The arithmetic is combinational logic in the top module, feeding the first slice.

Verification (EW=5, BIAS=15, FTZ=1, STAGES=2)
REQ-041 Nominal case: 15+15 -> E_r=15, E_raw=15, all flags 0, out_valid 2 cycles after accept.
REQ-042 Overflow and underflow: 30+30 -> E_raw=45, ovf=1, E_r=31; 3+5 -> E_raw=-7, unf=1, E_r=0; 8+7 -> E_raw=0, unf=1, E_r=0.
REQ-043 Special and zero inputs: 31+0 -> special=1, zero=1, E_r=31; 0+20 -> zero=1, E_r=0, unf=0.
REQ-044 Backpressure: stream 4 pairs with out_ready=0 for 3 cycles -> pipe fills, in_ready=0, outputs held stable; release -> 4 results in order with matching tags.
REQ-045 Reset mid-operation: assert rst_n low with 2 results in flight -> out_valid=0 immediately; after release, the new pair 16+16 -> E_r=17 with no stale output.
REQ-046 Random streaming with random out_ready toggling -> results match the reference model, with no drops or duplicates.

Source files
------------

// File: rtl/fp_mac_pkg.sv
// Purpose : format constants and result-flag type shared by the FP MAC exponent datapath.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   FP16_EW/FP16_BIAS, BF16_EW/BF16_BIAS, FP32_EW/FP32_BIAS : exponent width and bias per format
//   exp_flags_t : packed {ovf, unf, zero, special} result flags
//   FLAG_W      : bit width of exp_flags_t
package fp_mac_pkg;

    localparam int FP16_EW   = 5;
    localparam int FP16_BIAS = 15;
    localparam int BF16_EW   = 8;
    localparam int BF16_BIAS = 127;
    localparam int FP32_EW   = 8;
    localparam int FP32_BIAS = 127;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
        logic special;
    } exp_flags_t;

    localparam int FLAG_W = $bits(exp_flags_t);

endpackage : fp_mac_pkg

// File: rtl/pipe_stage_reg.sv
// Purpose : one valid/ready register slice carrying a W-bit payload.
// Latency : 1 cycle from in_valid&in_ready to out_valid.
// Backpressure: holds (bit-stable) while out_ready=0; in_ready = empty or draining this cycle.
//
// Ports:
//   clk, rst_n             : clock, async active-low reset
//   in_valid/in_ready      : upstream handshake
//   in_data                : payload captured on an accepted transfer
//   out_valid/out_ready    : downstream handshake
//   out_data               : registered payload
module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_vld;
    logic [W-1:0] r_dat;

    // The slice can take a new word when it is empty or its current word
    // leaves this cycle. This is the only combinational ready path, so a
    // chain of slices passes out_ready back without touching the valid path.
    assign in_ready = !r_vld || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (in_ready) begin
            r_vld <= in_valid;
            // Data only moves on a real transfer; during a bubble the old
            // payload stays put, which keeps the outputs quiet.
            if (in_valid) begin
                r_dat <= in_data;
            end
        end
    end

    assign out_valid = r_vld;
    assign out_data  = r_dat;

endmodule : pipe_stage_reg

// File: rtl/exp_bias_add_pipe.sv
// Purpose : biased exponent add for a floating-point multiplier (E_a + E_b - BIAS) with clamp and flags.
// Latency : STAGES cycles (1 or 2) from accepted operand pair to out_valid, one result per cycle.
// Backpressure: valid/ready; full pipe with out_ready=0 drops in_ready and freezes all outputs.
//
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_ready             : operand handshake (in_ready is 0 during and until the edge after reset)
//   E_a, E_b [EW]                 : biased exponent fields
//   in_tag [TAGW]                 : sideband tag, carried unmodified
//   out_valid/out_ready           : result handshake
//   E_r [EW]                      : clamped biased result exponent
//   E_raw [EW+2]                  : signed unclamped E_a+E_b-BIAS for the normalizer
//   ovf, unf, zero, special       : result flags
//   out_tag [TAGW]                : tag travelling with the result
//
// Parameters: EW 4..11, BIAS, STAGES 1 or 2, FTZ (nonzero = flush zero inputs), TAGW.
module exp_bias_add_pipe
    import fp_mac_pkg::*;
#(
    parameter int EW     = FP16_EW,
    parameter int BIAS   = 2**(EW-1)-1,
    parameter int STAGES = 1,
    parameter int FTZ    = 1,
    parameter int TAGW   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [EW-1:0]   E_a,
    input  logic [EW-1:0]   E_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [EW-1:0]   E_r,
    output logic [EW+1:0]   E_raw,
    output logic            ovf,
    output logic            unf,
    output logic            zero,
    output logic            special,
    output logic [TAGW-1:0] out_tag
);

    // Two guard bits: the top one is the sign, the other absorbs the carry of
    // two EW-bit operands, so the result never wraps for any input pair.
    localparam int            RW     = EW + 2;
    localparam logic [RW-1:0] BIAS_X = RW'(BIAS);
    localparam logic [RW-1:0] MAXE_X = RW'((2**EW) - 1);

    // Payload layout, MSB first: tag, E_r, E_raw, flags.
    localparam int PW = TAGW + EW + RW + FLAG_W;

    //------------------------------------------------------------------
    // Reset release gate
    //------------------------------------------------------------------
    // Cleared asynchronously by reset and set on the first edge after
    // release. It keeps in_ready low while rst_n is low (the empty slices
    // would otherwise advertise ready) and blocks any transfer on the
    // release edge itself.
    logic r_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    //------------------------------------------------------------------
    // Stage-1 combinational arithmetic
    //------------------------------------------------------------------
    logic [RW-1:0] w_raw;
    logic          w_special;
    logic          w_zero;
    logic          w_ovf;
    logic          w_unf;
    logic          w_raw_le0;
    logic [EW-1:0] w_er;
    exp_flags_t    w_flags;

    // Zero-extend both operands, then subtract the bias; the modular sum in
    // RW bits is the exact two's-complement result.
    assign w_raw = {2'b00, E_a} + {2'b00, E_b} - BIAS_X;

    assign w_special = (E_a == '1) || (E_b == '1);
    assign w_zero    = (E_a == '0) || (E_b == '0);

    // Overflow compares against the all-ones code: that code is reserved
    // for Inf/NaN, so landing on it is already out of range.
    assign w_ovf     = ($signed(w_raw) >= $signed(MAXE_X)) && !w_special;

    // Non-positive means negative (sign bit) or exactly zero.
    assign w_raw_le0 = w_raw[RW-1] || (w_raw == '0);
    assign w_unf     = w_raw_le0 && !w_special && !w_zero;

    // Result exponent precedence: special dominates, so Inf*0 yields the
    // all-ones code even though zero is also flagged. With FTZ off a zero
    // input only raises the flag and the numeric rules decide E_r.
    always_comb begin
        w_er = w_raw[EW-1:0];
        if (w_special) begin
            w_er = '1;
        end else if (w_zero && (FTZ != 0)) begin
            w_er = '0;
        end else if (w_ovf) begin
            w_er = '1;
        end else if (w_unf) begin
            w_er = '0;
        end
    end

    always_comb begin
        w_flags         = '0;
        w_flags.ovf     = w_ovf;
        w_flags.unf     = w_unf;
        w_flags.zero    = w_zero;
        w_flags.special = w_special;
    end

    //------------------------------------------------------------------
    // Register slice chain
    //------------------------------------------------------------------
    // Index 0 is the combinational input side, index STAGES the output side.
    // Slices after the first only re-register the payload.
    logic          w_vld [0:STAGES];
    logic          w_rdy [0:STAGES];
    logic [PW-1:0] w_dat [0:STAGES];

    assign w_vld[0]      = in_valid && r_run;
    assign w_dat[0]      = {in_tag, w_er, w_raw, w_flags};
    assign w_rdy[STAGES] = out_ready;
    assign in_ready      = w_rdy[0] && r_run;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            pipe_stage_reg #(
                .W (PW)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (w_vld[gi]),
                .in_ready  (w_rdy[gi]),
                .in_data   (w_dat[gi]),
                .out_valid (w_vld[gi+1]),
                .out_ready (w_rdy[gi+1]),
                .out_data  (w_dat[gi+1])
            );
        end
    endgenerate

    //------------------------------------------------------------------
    // Output unpack
    //------------------------------------------------------------------
    exp_flags_t w_out_flags;

    assign out_valid   = w_vld[STAGES];
    assign {out_tag, E_r, E_raw, w_out_flags} = w_dat[STAGES];
    assign ovf         = w_out_flags.ovf;
    assign unf         = w_out_flags.unf;
    assign zero        = w_out_flags.zero;
    assign special     = w_out_flags.special;

endmodule : exp_bias_add_pipe

// File: tb/tb_exp_bias_add_pipe.sv
module tb_exp_bias_add_pipe;

    localparam int EW     = 5;
    localparam int TAGW   = 4;
    localparam int STAGES = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [EW-1:0]   E_a = '0;
    logic [EW-1:0]   E_b = '0;
    logic [TAGW-1:0] in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [EW-1:0]   E_r;
    logic [EW+1:0]   E_raw;
    logic            ovf, unf, zero, special;
    logic [TAGW-1:0] out_tag;

    typedef struct packed {
        logic [EW-1:0]   er;
        logic [EW+1:0]   raw;
        logic            ovf;
        logic            unf;
        logic            zero;
        logic            special;
        logic [TAGW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    exp_t mon_got;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    exp_bias_add_pipe #(
        .EW     (EW),
        .BIAS   (15),
        .STAGES (STAGES),
        .FTZ    (1),
        .TAGW   (TAGW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .E_a       (E_a),
        .E_b       (E_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .E_r       (E_r),
        .E_raw     (E_raw),
        .ovf       (ovf),
        .unf       (unf),
        .zero      (zero),
        .special   (special),
        .out_tag   (out_tag)
    );

    // Reference model for EW=5, BIAS=15, FTZ=1.
    function automatic exp_t model(input logic [4:0] a, input logic [4:0] b, input logic [3:0] t);
        exp_t e;
        int   r;
        r         = int'(a) + int'(b) - 15;
        e.special = (a == 5'd31) || (b == 5'd31);
        e.zero    = (a == 5'd0) || (b == 5'd0);
        e.ovf     = (r >= 31) && !e.special;
        e.unf     = (r <= 0) && !e.special && !e.zero;
        if (e.special)   e.er = 5'd31;
        else if (e.zero) e.er = 5'd0;
        else if (e.ovf)  e.er = 5'd31;
        else if (e.unf)  e.er = 5'd0;
        else             e.er = r[4:0];
        e.raw = r[6:0];
        e.tag = t;
        return e;
    endfunction

    // Scoreboard: inputs are driven #1 after posedge, so both handshakes are
    // stable at the negedge that precedes the transfer edge.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sb.push_back(model(E_a, E_b, in_tag));
        end
        if (rst_n && out_valid && out_ready) begin
            mon_got = '{er: E_r, raw: E_raw, ovf: ovf, unf: unf, zero: zero, special: special, tag: out_tag};
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got er=%0d raw=%0d tag=%0d, expected no output", E_r, E_raw, out_tag);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    n_err++;
                    $display("FAIL sb_result: got er=%0d raw=%0d f=%b%b%b%b tag=%0d, expected er=%0d raw=%0d f=%b%b%b%b tag=%0d",
                             mon_got.er, mon_got.raw, mon_got.ovf, mon_got.unf, mon_got.zero, mon_got.special, mon_got.tag,
                             mon_exp.er, mon_exp.raw, mon_exp.ovf, mon_exp.unf, mon_exp.zero, mon_exp.special, mon_exp.tag);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            tick();
            n++;
        end
        n_cmp++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain: %0d results still pending, out_valid=%b, expected 0 and 0", sb.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
        end
        n_cmp++;
        if ({E_r, E_raw, ovf, unf, zero, special, out_tag} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, expected 0", {E_r, E_raw, ovf, unf, zero, special, out_tag});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_before_edge: in_ready=%b, expected 0", in_ready);
        end
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_after_edge: in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic test_nominal();
        out_ready = 1'b1;
        E_a = 5'd15; E_b = 5'd15; in_tag = 4'd1; in_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL nominal_accept: in_ready=%b, expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL nominal_latency_early: out_valid=%b after 1 cycle, expected 0", out_valid);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || E_r !== 5'd15 || E_raw !== 7'd15 || {ovf, unf, zero, special} !== 4'b0000 || out_tag !== 4'd1) begin
            n_err++;
            $display("FAIL nominal_result: valid=%b er=%0d raw=%0d f=%b%b%b%b tag=%0d, expected 1 15 15 0000 1",
                     out_valid, E_r, E_raw, ovf, unf, zero, special, out_tag);
        end
        tick();
    endtask

    task automatic test_corners();
        int va [9] = '{30, 3, 8, 31, 0, 1, 23, 22, 31};
        int vb [9] = '{30, 5, 7,  0, 20, 1, 23, 23, 31};
        int ve [9] = '{31, 0, 0, 31, 0, 0, 31, 30, 31};
        int vr [9] = '{45, -7, 0, 16, 5, -13, 31, 30, 47};
        logic [3:0] vf [9] = '{4'b1000, 4'b0100, 4'b0100, 4'b0011, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001};
        logic [6:0] raw_x;
        int         n;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            E_a = 5'(va[i]); E_b = 5'(vb[i]); in_tag = 4'(i); in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 8) begin
                @(negedge clk);
                n++;
            end
            raw_x = 7'(vr[i]);
            n_cmp++;
            if (out_valid !== 1'b1 || E_r !== 5'(ve[i]) || E_raw !== raw_x || {ovf, unf, zero, special} !== vf[i]) begin
                n_err++;
                $display("FAIL corner_%0d_%0d: valid=%b er=%0d raw=%0d f=%b%b%b%b, expected 1 %0d %0d %b",
                         va[i], vb[i], out_valid, E_r, E_raw, ovf, unf, zero, special, ve[i], raw_x, vf[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int         k = 0;
        int         cyc = 0;
        logic       acc;
        logic [19:0] snap = '0;
        int         pa [4] = '{10, 20, 29, 7};
        int         pb [4] = '{12, 5, 14, 9};
        out_ready = 1'b0;
        E_a = 5'(pa[0]); E_b = 5'(pb[0]); in_tag = 4'd8; in_valid = 1'b1;
        while (k < 4 && cyc < 40) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (cyc == 2) begin
                n_cmp++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_full: in_ready=%b out_valid=%b, expected 0 1", in_ready, out_valid);
                end
                snap = {E_r, E_raw, ovf, unf, zero, special, out_tag};
            end
            if (cyc == 3) begin
                n_cmp++;
                if ({E_r, E_raw, ovf, unf, zero, special, out_tag} !== snap || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_stable: got %h valid=%b, expected %h valid=1",
                             {E_r, E_raw, ovf, unf, zero, special, out_tag}, out_valid, snap);
                end
            end
            tick();
            if (cyc == 3) out_ready = 1'b1;
            if (acc) begin
                k++;
                if (k < 4) begin
                    E_a = 5'(pa[k]); E_b = 5'(pb[k]); in_tag = 4'(8 + k);
                end else begin
                    in_valid = 1'b0;
                end
            end
            cyc++;
        end
        n_cmp++;
        if (k != 4) begin
            n_err++;
            $display("FAIL bp_timeout: accepted %0d pairs, expected 4", k);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int n;
        out_ready = 1'b0;
        E_a = 5'd5; E_b = 5'd6; in_tag = 4'd2; in_valid = 1'b1;
        tick();
        E_a = 5'd9; E_b = 5'd9; in_tag = 4'd3;
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_immediate: out_valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
        end
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        E_a = 5'd16; E_b = 5'd16; in_tag = 4'd5; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        tick();
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (out_valid !== 1'b1 || E_r !== 5'd17 || E_raw !== 7'd17 || out_tag !== 4'd5) begin
            n_err++;
            $display("FAIL midreset_first: valid=%b er=%0d raw=%0d tag=%0d, expected 1 17 17 5",
                     out_valid, E_r, E_raw, out_tag);
        end
        drain();
    endtask

    task automatic test_random();
        logic        acc;
        logic        prev_hold = 1'b0;
        logic [19:0] prev = '0;
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (prev_hold) begin
                n_cmp++;
                if ({E_r, E_raw, ovf, unf, zero, special, out_tag} !== prev || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL random_stable: got %h valid=%b, expected %h valid=1",
                             {E_r, E_raw, ovf, unf, zero, special, out_tag}, out_valid, prev);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev      = {E_r, E_raw, ovf, unf, zero, special, out_tag};
            tick();
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 4) != 0);
                E_a      = 5'($urandom_range(0, 31));
                E_b      = 5'($urandom_range(0, 31));
                in_tag   = 4'($urandom_range(0, 15));
            end
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_corners();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_exp_bias_add_pipe
